// File: rtl/video_fetch_pkg.sv
// Shared encodings for the video line fetcher: FSM states and the
// adapter's transfer-size / direction codes.
package video_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    localparam logic [1:0] SZ_BYTE  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/line_fifo.sv
// First-word-fall-through FIFO with synchronous flush; head word is
// presented on pop_data whenever empty is low.
module line_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_nxt;

    assign full      = (count == CW'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);
    assign pop_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/video_line_fetcher.sv
// Fetches one video line of 32-bit words from the SDRAM adapter into a
// line FIFO, one transaction at a time, reserving a FIFO slot per request.
module video_line_fetcher
    import video_fetch_pkg::*;
#(
    parameter int WORDS_PER_LINE = 160,
    parameter int FIFO_DEPTH     = 16,
    parameter int AW             = 25
) (
    input  logic          PixelClk2,
    input  logic          Reset,
    input  logic          LineStart,
    input  logic [AW-1:0] LineBase,
    output logic [AW-1:0] Address,
    output logic [31:0]   DataWrite,
    output logic [1:0]    DataSize,
    output logic          ReadWrite,
    output logic          Request,
    input  logic          Ready,
    input  logic [31:0]   DataRead,
    input  logic          PopEn,
    output logic [31:0]   PopData,
    output logic          Empty,
    output logic          Underrun,
    output logic          LineDone
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state, state_nxt;
    logic          req_nxt;
    logic [AW-1:0] addr_nxt;
    logic [AW-1:0] base;
    logic [9:0]    index;
    logic          discard;
    logic          done_txn;
    logic          push;
    logic          slot_free;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic [CW:0]   occupancy;

    assign DataWrite = '0;
    assign DataSize  = SZ_DWORD;
    assign ReadWrite = RW_READ;

    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, (state != ST_IDLE)};
    assign slot_free = !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));

    always_ff @(posedge PixelClk2 or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            Request <= 1'b0;
            Address <= '0;
        end else begin
            state   <= state_nxt;
            Request <= req_nxt;
            Address <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = Request;
        addr_nxt  = Address;
        done_txn  = 1'b0;
        push      = 1'b0;
        case (state)
            // No issue on a LineStart edge: the new base is not latched yet.
            ST_IDLE: begin
                if (!LineStart && !LineDone && (index < 10'(WORDS_PER_LINE)) &&
                    slot_free && Ready) begin
                    req_nxt   = 1'b1;
                    addr_nxt  = base + AW'({index, 2'b00});
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!Ready) begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (Ready) begin
                    done_txn  = 1'b1;
                    push      = !discard && !LineStart;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PixelClk2 or posedge Reset) begin
        if (Reset) begin
            base     <= '0;
            index    <= '0;
            discard  <= 1'b0;
            LineDone <= 1'b1;
            Underrun <= 1'b0;
        end else if (LineStart) begin
            base     <= {LineBase[AW-1:2], 2'b00};
            index    <= '0;
            LineDone <= 1'b0;
            Underrun <= 1'b0;
            // A transaction still in flight belongs to the old line.
            discard  <= (state_nxt != ST_IDLE);
        end else begin
            if (state_nxt == ST_IDLE) discard <= 1'b0;
            if (done_txn && !discard) index <= index + 10'd1;
            if (push && (index == 10'(WORDS_PER_LINE - 1))) LineDone <= 1'b1;
            if (PopEn && Empty) Underrun <= 1'b1;
        end
    end

    line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk       (PixelClk2),
        .rst       (Reset),
        .push      (push),
        .push_data (DataRead),
        .pop       (PopEn),
        .flush     (LineStart),
        .pop_data  (PopData),
        .count     (fifo_count),
        .empty     (Empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_video_line_fetcher.sv
// Bench for video_line_fetcher: behavioural SDRAM adapter, address and
// pop-order scoreboard, table of line bases plus multi-cycle corner cases.
module tb_video_line_fetcher;

    localparam int WPL   = 160;
    localparam int DEPTH = 16;
    localparam int AW    = 25;

    logic          clk = 1'b0;
    logic          Reset;
    logic          LineStart;
    logic [AW-1:0] LineBase;
    logic [AW-1:0] Address;
    logic [31:0]   DataWrite;
    logic [1:0]    DataSize;
    logic          ReadWrite;
    logic          Request;
    logic          Ready = 1'b1;
    logic [31:0]   DataRead = '0;
    logic          PopEn = 1'b0;
    logic [31:0]   PopData;
    logic          Empty;
    logic          Underrun;
    logic          LineDone;

    video_line_fetcher #(.WORDS_PER_LINE(WPL), .FIFO_DEPTH(DEPTH), .AW(AW)) dut (
        .PixelClk2(clk), .Reset(Reset), .LineStart(LineStart), .LineBase(LineBase),
        .Address(Address), .DataWrite(DataWrite), .DataSize(DataSize),
        .ReadWrite(ReadWrite), .Request(Request), .Ready(Ready), .DataRead(DataRead),
        .PopEn(PopEn), .PopData(PopData), .Empty(Empty), .Underrun(Underrun),
        .LineDone(LineDone)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] b, input int i);
        return AW'(b + AW'(i * 4));
    endfunction

    // Knobs written only by the main sequence.
    int   pop_mode  = 0;     // 0: never pop, 1: random pops while non-empty
    int   pop_pct   = 50;
    logic force_pop = 1'b0;  // one-cycle PopEn regardless of Empty
    logic lat_rand  = 1'b0;
    int   lat_fix   = 2;

    // Scoreboard / adapter state, written only by the negedge engine.
    int            iss_idx = 0, pop_idx = 0, tot_iss = 0;
    int            neg_cnt = 0, last_ret = 0, lat_cnt = 0;
    logic          busy = 1'b0, req_prev = 1'b0, line_busy = 1'b0, stale_pending = 1'b0;
    logic [AW-1:0] cur_base = '0, cur_addr = '0;
    logic [AW-1:0] a_first = '0, a_second = '0, a_last = '0;

    always @(negedge clk) begin
        neg_cnt++;
        PopEn = 1'b0;
        if (Reset) begin
            Ready = 1'b1; busy = 1'b0; req_prev = 1'b0;
            line_busy = 1'b0; stale_pending = 1'b0;
        end else begin
            if (Request && !req_prev) begin
                tot_iss++;
                check("stale_wait", 32'(stale_pending), 32'd0);
                check("req_addr", 32'(Address), 32'(word_addr(cur_base, iss_idx)));
                if (iss_idx == 0) a_first = Address;
                if (iss_idx == 1) a_second = Address;
                a_last = Address;
                iss_idx++;
                check("slot_limit", 32'(iss_idx - pop_idx <= DEPTH), 32'd1);
            end
            req_prev = Request;

            if (LineStart) begin
                cur_base = {LineBase[AW-1:2], 2'b00};
                iss_idx = 0; pop_idx = 0; line_busy = 1'b1;
                stale_pending = busy || Request;
            end else if (line_busy && LineDone) begin
                check("done_count", 32'(iss_idx), 32'(WPL));
                check("done_timing", 32'(neg_cnt - last_ret), 32'd1);
                line_busy = 1'b0;
            end

            if (!busy) begin
                if (Request && Ready) begin
                    busy = 1'b1; Ready = 1'b0; cur_addr = Address;
                    lat_cnt = lat_rand ? int'($urandom_range(4, 0)) : lat_fix;
                end
            end else if (lat_cnt > 0) begin
                lat_cnt--;
            end else begin
                busy = 1'b0; Ready = 1'b1; DataRead = 32'(cur_addr);
                last_ret = neg_cnt; stale_pending = 1'b0;
            end

            if (!LineStart && (force_pop ||
                (pop_mode == 1 && !Empty && int'($urandom_range(99, 0)) < pop_pct))) begin
                PopEn = 1'b1;
                if (!Empty) begin
                    check("pop_in_line", 32'(pop_idx < WPL), 32'd1);
                    check("pop_data", PopData, 32'(word_addr(cur_base, pop_idx)));
                    pop_idx++;
                end
            end
        end
    end

    task automatic start_line(input logic [AW-1:0] b);
        LineBase = b; LineStart = 1'b1;
        @(posedge clk); #1;
        LineStart = 1'b0;
    endtask

    task automatic wait_line(input string name);
        int n = 0;
        while ((line_busy || pop_idx != WPL) && n < 8000) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_timeout"}, 32'(n < 8000), 32'd1);
        check({name, "_done"}, 32'(LineDone), 32'd1);
        check({name, "_empty"}, 32'(Empty), 32'd1);
        check({name, "_issued"}, 32'(iss_idx), 32'(WPL));
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            pct;
        logic          rnd;
        logic [AW-1:0] a0, a1, alast;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int n;
        logic [AW-1:0] rb;
        tbl[0] = '{25'h0000100, 100, 1'b0, 25'h0000100, 25'h0000104, 25'h000037C};
        tbl[1] = '{25'h1FFFFFC,  40, 1'b1, 25'h1FFFFFC, 25'h0000000, 25'h0000278};
        tbl[2] = '{25'h1000003,  70, 1'b1, 25'h1000000, 25'h1000004, 25'h100027C};
        tbl[3] = '{25'h0ABCDE1,  25, 1'b0, 25'h0ABCDE0, 25'h0ABCDE4, 25'h0ABD05C};

        Reset = 1'b1; LineStart = 1'b0; LineBase = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_request", 32'(Request), 32'd0);
        check("rst_address", 32'(Address), 32'd0);
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_underrun", 32'(Underrun), 32'd0);
        check("rst_linedone", 32'(LineDone), 32'd1);
        check("const_size", 32'(DataSize), 32'd3);
        check("const_rw", 32'(ReadWrite), 32'd0);
        check("const_wdata", DataWrite, 32'd0);
        Reset = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("idle_no_req", 32'(tot_iss), 32'd0);

        foreach (tbl[i]) begin
            pop_mode = 1; pop_pct = tbl[i].pct; lat_rand = tbl[i].rnd; lat_fix = 2;
            start_line(tbl[i].base);
            wait_line("tbl");
            check("tbl_first", 32'(a_first), 32'(tbl[i].a0));
            check("tbl_second", 32'(a_second), 32'(tbl[i].a1));
            check("tbl_last", 32'(a_last), 32'(tbl[i].alast));
            check("tbl_underrun", 32'(Underrun), 32'd0);
        end

        for (int k = 0; k < 3; k++) begin
            rb = AW'($urandom);
            pop_mode = 1; pop_pct = int'($urandom_range(100, 20)); lat_rand = 1'b1;
            start_line(rb);
            wait_line("rnd");
            check("rnd_first", 32'(a_first), 32'({rb[AW-1:2], 2'b00}));
            check("rnd_underrun", 32'(Underrun), 32'd0);
        end

        // Never pop: slot reservation caps the line at FIFO_DEPTH words.
        pop_mode = 0; lat_rand = 1'b0; lat_fix = 2;
        start_line(25'h0004000);
        repeat (400) @(posedge clk); #1;
        check("np_issued", 32'(iss_idx), 32'(DEPTH));
        check("np_request", 32'(Request), 32'd0);
        check("np_empty", 32'(Empty), 32'd0);
        force_pop = 1'b1; @(posedge clk); #1; force_pop = 1'b0;
        repeat (100) @(posedge clk); #1;
        check("np_one_more", 32'(iss_idx), 32'(DEPTH + 1));
        check("np_popped", 32'(pop_idx), 32'd1);

        // Pop on an empty FIFO straight after LineStart.
        start_line(25'h0008000);
        force_pop = 1'b1; @(posedge clk); #1; force_pop = 1'b0;
        check("ur_set", 32'(Underrun), 32'd1);
        check("ur_empty", 32'(Empty), 32'd1);
        pop_mode = 1; pop_pct = 60;
        wait_line("ur");
        check("ur_sticky", 32'(Underrun), 32'd1);

        // LineStart while a transaction is in WAIT: its data must be dropped.
        lat_fix = 5;
        start_line(25'h0001000);
        check("ur_cleared", 32'(Underrun), 32'd0);
        n = 0;
        while (!(busy && !Request && lat_cnt >= 2 && iss_idx >= 3) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check("dc_reach_wait", 32'(n < 2000), 32'd1);
        start_line(25'h0002000);
        wait_line("dc");
        check("dc_first", 32'(a_first), 32'h2000);

        // Reset while Request=1 and Ready=1.
        lat_fix = 2;
        start_line(25'h0003000);
        n = 0;
        while (!(Request && Ready) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check("rr_reach_req", 32'(n < 2000), 32'd1);
        Reset = 1'b1; #1;
        check("rr_req_async", 32'(Request), 32'd0);
        check("rr_addr_async", 32'(Address), 32'd0);
        check("rr_linedone", 32'(LineDone), 32'd1);
        n = tot_iss;
        repeat (3) @(posedge clk); #1;
        Reset = 1'b0;
        repeat (40) @(posedge clk); #1;
        check("rr_no_req", 32'(tot_iss), 32'(n));
        start_line(25'h0003000);
        wait_line("rr");
        check("rr_first", 32'(a_first), 32'h3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_line_fetcher.md
Name: video_line_fetcher

Overview:
- Upstream master of the SDRAM memory adapter.
- On each line-start strobe, issues consecutive 32-bit read requests over the adapter's Request/Ready handshake, starting at a programmable byte base address.
- Returned words are buffered in a line FIFO that the pixel serializer pops.
- Decouples bursty SDRAM latency from the constant-rate pixel pipeline in the PixelClk2 domain.

Parameters:
WORDS_PER_LINE, 160, 32-bit words fetched per line (1..1023)
FIFO_DEPTH, 16, FIFO entries; power of two, 4..64
AW, 25, adapter byte-address width

Ports:
PixelClk2  in  1  sole clock; all logic on rising edge
Reset  in  1  asynchronous, active-high
LineStart  in  1  one-cycle strobe: begin fetching a new line
LineBase  in  AW  byte address of word 0; sampled on LineStart; bits[1:0] ignored (forced 0)
Address  out  AW  adapter byte address
DataWrite  out  32  constant 0
DataSize  out  2  constant 2'b11 (32-bit)
ReadWrite  out  1  constant 0 (read)
Request  out  1  adapter request
Ready  in  1  adapter idle / data-valid indication
DataRead  in  32  adapter read data
PopEn  in  1  pixel side consumes head word this cycle
PopData  out  32  FIFO head word, valid when Empty=0
Empty  out  1  FIFO empty
Underrun  out  1  sticky: PopEn seen while Empty=1
LineDone  out  1  high once all WORDS_PER_LINE words of the current line are pushed

Behaviour:
- Reset values: Request=0, Address=0, Empty=1, Underrun=0, LineDone=1, FIFO count=0, state IDLE.
- Request, Address, Empty, Underrun and LineDone are registered.
- Address = {base[AW-1:2],2'b00} + 4*index, with a 10-bit word index. Byte-address arithmetic wraps modulo 2^AW.
- Slot reservation: a request may issue only if (fifo_count + inflight) < FIFO_DEPTH. At most one transaction is in flight.

FSM:
- IDLE:
  - If a line is active, index < WORDS_PER_LINE, a slot is free and Ready=1: drive Address, set Request=1, go to REQ.
- REQ:
  - Hold Request=1 until Ready is sampled 0 (adapter accepted).
  - Then Request=0 and go to WAIT.
  - Request is never high for more than one cycle after Ready falls.
- WAIT:
  - When Ready is sampled 1, DataRead is valid.
  - Push DataRead unless the transaction is marked discard.
  - index++, go to IDLE.
  - An issue from IDLE requires at least one further cycle (no back-to-back in the same edge).
- Requests are never raised while Ready=0, so a transaction the adapter had in progress before Reset completes harmlessly.

LineStart:
- Latches LineBase, sets index=0, clears the FIFO, clears LineDone and Underrun.
- If in REQ or WAIT, the in-flight transaction completes normally but its data is discarded. The first new-line request issues only after that transaction returns to IDLE.
- LineStart while already in IDLE with a pending line restarts cleanly.

FIFO:
- Push and pop in the same cycle: count unchanged, both honoured.
- Pop while Empty: ignored, Underrun=1, FIFO unchanged.
- Push never occurs while full, guaranteed by slot reservation.
- PopData is valid in the same cycle Empty=0 (first-word fall-through).

LineDone rises in the cycle after the last push.

Decomposition:
- Package video_fetch_pkg holds:
  - FSM state encoding (IDLE/REQ/WAIT);
  - DataSize constants SZ_BYTE=2'b01, SZ_WORD=2'b10, SZ_DWORD=2'b11;
  - RW_READ=0 / RW_WRITE=1.
- One sub-module, line_fifo: synchronous first-word-fall-through FIFO with push, pop, flush, count, empty and full outputs; parameters DEPTH and width 32.

Test Plan:
- Reset, then LineStart with LineBase=0x000100 and an adapter model (Ready drop 1 cycle after Request, data 3 cycles later = address) -> Addresses 0x100, 0x104, ... 0x37C. FIFO pops return the same values in order. LineDone=1 after the 160th push.
- Never pop, WORDS_PER_LINE=160, FIFO_DEPTH=16 -> exactly 16 requests issued, then Request stays 0. One pop -> exactly one more request.
- PopEn with Empty=1 right after LineStart -> Underrun=1, FIFO contents unchanged. Next LineStart -> Underrun=0.
- LineStart during WAIT (base 0x1000 then 0x2000) -> stale word is not pushed. The next Address is 0x2000, issued only after Ready returns to 1.
- LineBase=0x1FFFFFC -> first Address 0x1FFFFFC, second Address 0x0000000 (wrap).
- Assert Reset while Request=1 and Ready=1 -> Request=0 asynchronously. No new request until the line restarts via LineStart with Ready=1.
